arm_barrel_shift_stage: RTL and testbench
=========================================

// Module: arm_barrel_shift_stage
// PURPOSE
//  Multi-cycle ARM shifter-operand stage, directly upstream of the ALU B input.
//  Applies LSL/LSR/ASR/ROR/RRX to Rm by an immediate or register-specified amount,
//  one bit position per clock. Produces the shifted operand plus the shifter carry-out.
//  The carry-out feeds the C flag for logical ops (AND/EOR/ORR/BIC/MVN/TST/TEQ/bypass).
// PARAMETERS
//  DATA_W  32  operand width; only 32 is supported (ARM semantics)
//  CNT_W   6   width of internal step counter; holds 0..33
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  START      in   1       request; sampled only in IDLE
//  RM         in   DATA_W  value to shift
//  SHIFT_TYPE in   2       00 LSL, 01 LSR, 10 ASR, 11 ROR
//  SHIFT_AMT  in   8       amount; register form uses all 8 bits, immediate uses [4:0]
//  IMM_FORM   in   1       1 = immediate encoding (amount 0 has special meaning)
//  C_IN       in   1       current CPSR C flag
//  SHIFT_OUT  out  DATA_W  shifted operand, to ALU B
//  C_OUT      out  1       shifter carry-out
//  BUSY       out  1       high in SHIFT and DONE states
//  DONE       out  1       one-cycle pulse; SHIFT_OUT/C_OUT valid from this cycle on
// BEHAVIOUR
//  Reset (async): state=IDLE, SHIFT_OUT=0, C_OUT=0, BUSY=0, DONE=0.
//  Reset mid-operation aborts the shift. No DONE is issued for the aborted request.
//  FSM states: IDLE -> (START) SHIFT -> (count==0) DONE -> IDLE.
//  START in SHIFT/DONE is ignored; no queueing.
//  On accepted START: latch RM into SHIFT_OUT; set C_OUT=C_IN; load step count N.
//  N rules, with amt = SHIFT_AMT (immediate: amt = SHIFT_AMT[4:0]):
//   - Immediate form, amt==0:
//     - LSL: N=0 (pass-through, C_OUT=C_IN).
//     - LSR: N=32.
//     - ASR: N=32.
//     - ROR: RRX, N=1.
//   - Register form, amt==0: N=0, pass-through, C_OUT=C_IN.
//   - LSL/LSR: N = min(amt,33).
//     - 32 gives result 0, C = last bit out.
//     - 33 and above gives result 0, C=0.
//   - ASR: N = min(amt,32). Beyond 32 the result equals the 32 case.
//   - ROR (not RRX): N = amt[4:0].
//     - If amt[4:0]==0 and amt!=0: N=0, result RM, C_OUT=RM[31].
//  Each SHIFT-state cycle with N>0 performs one step, then N<=N-1:
//   - LSL: C<=v[31]; v<={v[30:0],0}.
//   - LSR: C<=v[0]; v<={0,v[31:1]}.
//   - ASR: C<=v[0]; v<={v[31],v[31:1]}.
//   - ROR: C<=v[0]; v<={v[0],v[31:1]}.
//   - RRX: C<=v[0]; v<={C_latched,v[31:1]}.
//  SHIFT with N==0 performs no step and moves to DONE.
//  Latency: START accepted at edge k; DONE high during the cycle after edge k+N+1.
//   - Zero-count requests: DONE after edge k+1.
//   - Worst case (LSL/LSR by 33 or more): DONE after edge k+34.
//  DONE is high for exactly one cycle.
//  SHIFT_OUT and C_OUT hold their values after DONE until the next accepted START.
//  Inputs other than START are don't-care after acceptance.
//  C_IN is latched at acceptance for both RRX and pass-through.
// TESTING
//  - LSL imm #4, RM=0x000000F1, C_IN=0
//    -> SHIFT_OUT=0x00000F10, C_OUT=0; DONE after edge k+5, one cycle wide.
//  - LSR reg amt=32, RM=0x80000001 -> 0x00000000, C_OUT=1.
//    - Same with amt=40 -> 0x00000000, C_OUT=0.
//  - ASR imm #0, RM=0x80000000 -> 0xFFFFFFFF, C_OUT=1, DONE after edge k+33.
//  - RRX (ROR imm #0), RM=0x00000003, C_IN=1 -> 0x80000001, C_OUT=1.
//  - ROR reg amt=0x20, RM=0x80000000 -> 0x80000000, C_OUT=1, DONE after edge k+1.
//    - Register amt=0, C_IN=1 -> RM unchanged, C_OUT=1.
//  - START pulsed again mid-shift -> ignored, first result intact.
//    - reset asserted mid-shift -> outputs 0, IDLE, no DONE.

Source files
------------

// File: rtl/arm_barrel_shift_stage.sv
// Multi-cycle ARM shifter-operand stage: shifts Rm one bit position per clock and
// produces the shifter carry-out that feeds the C flag of logical operations.

module arm_barrel_shift_stage_chk #(
    parameter int CNT_W = 6
) (
    input logic             clk,
    input logic             reset,
    input logic             busy,
    input logic             done,
    input logic [CNT_W-1:0] count
);

    a_done_in_busy: assert property (@(posedge clk) disable iff (reset) done |-> busy);
    a_done_pulse:   assert property (@(posedge clk) disable iff (reset) done |=> !done);
    a_count_range:  assert property (@(posedge clk) disable iff (reset) count <= CNT_W'(6'd33));

endmodule

module arm_barrel_shift_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              START,
    input  logic [DATA_W-1:0] RM,
    input  logic [1:0]        SHIFT_TYPE,
    input  logic [7:0]        SHIFT_AMT,
    input  logic              IMM_FORM,
    input  logic              C_IN,
    output logic [DATA_W-1:0] SHIFT_OUT,
    output logic              C_OUT,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0]       OP_LSL = 2'b00;
    localparam logic [1:0]       OP_LSR = 2'b01;
    localparam logic [1:0]       OP_ASR = 2'b10;
    localparam logic [1:0]       OP_ROR = 2'b11;
    localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(6'd1);
    localparam logic [CNT_W-1:0] CNT_32 = CNT_W'(6'd32);
    localparam logic [CNT_W-1:0] CNT_33 = CNT_W'(6'd33);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  load_count;
    logic [1:0]        op;
    logic              rrx;
    logic              rrx_carry;
    logic              load_rrx;
    logic              load_carry;
    logic [7:0]        amt;
    logic              accept;
    logic              step;
    logic              busy_next;
    logic              done_next;
    logic [DATA_W:0]   stepped;

    // One single-bit step; returns {carry, value}. RRX shifts the latched C flag into the top.
    function automatic logic [DATA_W:0] shift_step(
        input logic [DATA_W-1:0] v,
        input logic [1:0]        kind,
        input logic              is_rrx,
        input logic              fill
    );
        logic [DATA_W:0] r;
        if (is_rrx) begin
            r = {v[0], fill, v[DATA_W-1:1]};
        end else begin
            case (kind)
                OP_LSL:  r = {v[DATA_W-1], v[DATA_W-2:0], 1'b0};
                OP_LSR:  r = {v[0], 1'b0, v[DATA_W-1:1]};
                OP_ASR:  r = {v[0], v[DATA_W-1], v[DATA_W-1:1]};
                OP_ROR:  r = {v[0], v[0], v[DATA_W-1:1]};
                default: r = {v[0], v};
            endcase
        end
        return r;
    endfunction

    assign accept  = (state == ST_IDLE) && START;
    assign step    = (state == ST_SHIFT) && (count != '0);
    assign stepped = shift_step(SHIFT_OUT, op, rrx, rrx_carry);

    // Decode the step count and initial carry for a request; amount 0 is an encoding escape.
    always_comb begin
        amt        = IMM_FORM ? {3'b000, SHIFT_AMT[4:0]} : SHIFT_AMT;
        load_count = '0;
        load_carry = C_IN;
        load_rrx   = 1'b0;
        if (amt == 8'd0) begin
            if (IMM_FORM) begin
                case (SHIFT_TYPE)
                    OP_LSR, OP_ASR: load_count = CNT_32;
                    OP_ROR: begin
                        load_rrx   = 1'b1;
                        load_count = CNT_1;
                    end
                    default: load_count = '0;
                endcase
            end else begin
                load_count = '0;
            end
        end else begin
            case (SHIFT_TYPE)
                OP_LSL, OP_LSR: load_count = (amt > 8'd33) ? CNT_33 : amt[CNT_W-1:0];
                OP_ASR:         load_count = (amt > 8'd32) ? CNT_32 : amt[CNT_W-1:0];
                OP_ROR: begin
                    load_count = CNT_W'(amt[4:0]);
                    // Register rotate by a multiple of 32: value unchanged, carry is bit 31.
                    if (amt[4:0] == 5'd0) begin
                        load_carry = RM[DATA_W-1];
                    end else begin
                        load_carry = C_IN;
                    end
                end
                default: load_count = '0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    next_state = ST_SHIFT;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (count == '0) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_SHIFT;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Status outputs for the coming cycle, registered below.
    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        case (next_state)
            ST_SHIFT: busy_next = 1'b1;
            ST_DONE: begin
                busy_next = 1'b1;
                done_next = 1'b1;
            end
            default: begin
                busy_next = 1'b0;
                done_next = 1'b0;
            end
        endcase
    end

    // Registered BUSY/DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BUSY <= 1'b0;
            DONE <= 1'b0;
        end else begin
            BUSY <= busy_next;
            DONE <= done_next;
        end
    end

    // Operand, carry and step counter; results hold until the next accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            SHIFT_OUT <= '0;
            C_OUT     <= 1'b0;
            count     <= '0;
            op        <= OP_LSL;
            rrx       <= 1'b0;
            rrx_carry <= 1'b0;
        end else if (accept) begin
            SHIFT_OUT <= RM;
            C_OUT     <= load_carry;
            count     <= load_count;
            op        <= SHIFT_TYPE;
            rrx       <= load_rrx;
            rrx_carry <= C_IN;
        end else if (step) begin
            {C_OUT, SHIFT_OUT} <= stepped;
            count              <= count - CNT_1;
        end
    end

    arm_barrel_shift_stage_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .busy  (BUSY),
        .done  (DONE),
        .count (count)
    );

endmodule

// File: tb/tb_arm_barrel_shift_stage.sv
// Bench for arm_barrel_shift_stage: directed vectors against an arithmetic model of ARM
// shifter-operand semantics, with hand-computed literals pinning the model.

module tb_arm_barrel_shift_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        START;
    logic [31:0] RM;
    logic [1:0]  SHIFT_TYPE;
    logic [7:0]  SHIFT_AMT;
    logic        IMM_FORM;
    logic        C_IN;
    logic [31:0] SHIFT_OUT;
    logic        C_OUT;
    logic        BUSY;
    logic        DONE;

    arm_barrel_shift_stage #(.DATA_W(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .START      (START),
        .RM         (RM),
        .SHIFT_TYPE (SHIFT_TYPE),
        .SHIFT_AMT  (SHIFT_AMT),
        .IMM_FORM   (IMM_FORM),
        .C_IN       (C_IN),
        .SHIFT_OUT  (SHIFT_OUT),
        .C_OUT      (C_OUT),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    logic        exp_valid = 1'b0;
    logic        want_zero = 1'b1;
    logic        has_hand = 1'b0;
    logic [31:0] exp_val, hand_val;
    logic        exp_c, hand_c;
    int          exp_n, hand_n;
    int          acc = 0;
    int          op_id = 0;
    int          done_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (op %0d)", name, act, req, op_id);
        end
    endtask

    // ARM shifter-operand result from the architectural rules; n is the one-bit-per-clock step count.
    task automatic model_op(input logic [1:0] t, input logic [7:0] amt_in, input logic imm,
                            input logic [31:0] rm, input logic cin,
                            output logic [31:0] v, output logic c, output int n);
        int a;
        int r;
        a = imm ? int'(amt_in[4:0]) : int'(amt_in);
        v = rm;
        c = cin;
        n = 0;
        if (imm && a == 0 && t == 2'd3) begin
            v = {cin, rm[31:1]};
            c = rm[0];
            n = 1;
        end else begin
            if (imm && a == 0 && (t == 2'd1 || t == 2'd2)) a = 32;
            if (a != 0) begin
                case (t)
                    2'd0: begin
                        n = (a > 33) ? 33 : a;
                        if (a < 32) begin v = rm << a; c = rm[32 - a]; end
                        else begin v = 32'd0; c = (a == 32) ? rm[0] : 1'b0; end
                    end
                    2'd1: begin
                        n = (a > 33) ? 33 : a;
                        if (a < 32) begin v = rm >> a; c = rm[a - 1]; end
                        else begin v = 32'd0; c = (a == 32) ? rm[31] : 1'b0; end
                    end
                    2'd2: begin
                        n = (a > 32) ? 32 : a;
                        if (a < 32) begin v = 32'($signed(rm) >>> a); c = rm[a - 1]; end
                        else begin v = {32{rm[31]}}; c = rm[31]; end
                    end
                    default: begin
                        r = a % 32;
                        n = r;
                        if (r == 0) c = rm[31];
                        else begin v = (rm >> r) | (rm << (32 - r)); c = rm[r - 1]; end
                    end
                endcase
            end
        end
    endtask

    // Compare process: every falling edge, check the DUT against the current expectation.
    initial begin
        int seen_id;
        bit op_done;
        bit hold_chk;
        seen_id  = 0;
        op_done  = 1'b1;
        hold_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (want_zero) begin
                check("idle_shift_out", SHIFT_OUT, 32'd0);
                check("idle_c_out", 32'(C_OUT), 32'd0);
                check("idle_busy", 32'(BUSY), 32'd0);
                check("idle_done", 32'(DONE), 32'd0);
            end else if (exp_valid) begin
                if (op_id != seen_id) begin
                    seen_id  = op_id;
                    op_done  = 1'b0;
                    hold_chk = 1'b0;
                    if (has_hand) begin
                        check("model_value", exp_val, hand_val);
                        check("model_carry", 32'(exp_c), 32'(hand_c));
                        check("model_steps", 32'(exp_n), 32'(hand_n));
                    end
                end
                if (hold_chk) begin
                    hold_chk = 1'b0;
                    check("done_width", 32'(DONE), 32'd0);
                    check("hold_value", SHIFT_OUT, exp_val);
                    check("hold_carry", 32'(C_OUT), 32'(exp_c));
                end
                if (!op_done && cyc >= acc) begin
                    if (DONE === 1'b1) begin
                        check("result_value", SHIFT_OUT, exp_val);
                        check("result_carry", 32'(C_OUT), 32'(exp_c));
                        check("done_latency", 32'(cyc - acc), 32'(exp_n + 1));
                        check("busy_at_done", 32'(BUSY), 32'd1);
                        op_done  = 1'b1;
                        hold_chk = 1'b1;
                        done_count++;
                    end else begin
                        check("busy_in_shift", 32'(BUSY), 32'd1);
                        if (cyc - acc > exp_n + 4) begin
                            check("done_timeout", 32'(cyc - acc), 32'(exp_n + 1));
                            op_done = 1'b1;
                            done_count++;
                        end
                    end
                end
            end else begin
                check("no_spurious_done", 32'(DONE), 32'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] t, input logic [7:0] amt, input logic imm,
                         input logic [31:0] rm, input logic cin, input logic hand,
                         input logic [31:0] hv, input logic hc, input int hn);
        @(posedge clk); #2;
        model_op(t, amt, imm, rm, cin, exp_val, exp_c, exp_n);
        has_hand   = hand;
        hand_val   = hv;
        hand_c     = hc;
        hand_n     = hn;
        acc        = cyc + 1;
        op_id      = op_id + 1;
        exp_valid  = 1'b1;
        RM         = rm;
        SHIFT_TYPE = t;
        SHIFT_AMT  = amt;
        IMM_FORM   = imm;
        C_IN       = cin;
        START      = 1'b1;
        @(posedge clk); #2;
        START      = 1'b0;
        RM         = $urandom;
        SHIFT_AMT  = 8'($urandom);
        SHIFT_TYPE = 2'($urandom);
        IMM_FORM   = ~imm;
        C_IN       = ~cin;
    endtask

    task automatic run_op(input logic [1:0] t, input logic [7:0] amt, input logic imm,
                          input logic [31:0] rm, input logic cin, input logic hand,
                          input logic [31:0] hv, input logic hc, input int hn, input int restart_at);
        int start_cnt;
        issue(t, amt, imm, rm, cin, hand, hv, hc, hn);
        start_cnt = done_count;
        for (int i = 0; i < 60; i++) begin
            if (done_count != start_cnt) break;
            if (i == restart_at) begin
                START = 1'b1;
                RM    = 32'hFFFF_FFFF;
            end else begin
                START = 1'b0;
            end
            @(posedge clk); #2;
        end
        START = 1'b0;
        @(posedge clk); #2;
        exp_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        START      = 1'b0;
        RM         = 32'd0;
        SHIFT_TYPE = 2'd0;
        SHIFT_AMT  = 8'd0;
        IMM_FORM   = 1'b0;
        C_IN       = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 want_zero = 1'b0;

        //      type   amt    imm   RM             cin   hand  value          c     n   restart
        run_op(2'd0, 8'd4,   1'b1, 32'h0000_00F1, 1'b0, 1'b1, 32'h0000_0F10, 1'b0, 4,  -1);
        run_op(2'd1, 8'd32,  1'b0, 32'h8000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 32, -1);
        run_op(2'd1, 8'd40,  1'b0, 32'h8000_0001, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 33, -1);
        run_op(2'd2, 8'd0,   1'b1, 32'h8000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32, -1);
        run_op(2'd3, 8'd0,   1'b1, 32'h0000_0003, 1'b1, 1'b1, 32'h8000_0001, 1'b1, 1,  -1);
        run_op(2'd3, 8'h20,  1'b0, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 0,  -1);
        run_op(2'd0, 8'd0,   1'b0, 32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 0,  -1);
        run_op(2'd0, 8'd33,  1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 33, -1);
        run_op(2'd3, 8'd8,   1'b1, 32'h0000_00A5, 1'b0, 1'b1, 32'hA500_0000, 1'b1, 8,  -1);
        run_op(2'd2, 8'd4,   1'b0, 32'h8000_0010, 1'b1, 1'b1, 32'hF800_0001, 1'b0, 4,  -1);
        run_op(2'd0, 8'd0,   1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 0,  -1);
        run_op(2'd1, 8'h21,  1'b1, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1,  -1);
        run_op(2'd2, 8'd200, 1'b0, 32'h4000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32, -1);
        run_op(2'd3, 8'h40,  1'b0, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 0,  -1);
        run_op(2'd0, 8'd31,  1'b1, 32'h0000_0003, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 31, -1);
        // A second START while shifting must be ignored.
        run_op(2'd0, 8'd20,  1'b1, 32'h0000_0001, 1'b0, 1'b1, 32'h0010_0000, 1'b0, 20, 3);
        run_op(2'd3, 8'd13,  1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0,         1'b0, 0,  -1);

        // Reset in the middle of a shift: outputs clear and no DONE follows.
        issue(2'd0, 8'd20, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b0, 0);
        repeat (5) @(posedge clk);
        #2;
        exp_valid = 1'b0;
        want_zero = 1'b1;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (40) @(posedge clk);
        #2 want_zero = 1'b0;

        run_op(2'd1, 8'd1,   1'b1, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1,  -1);

        @(posedge clk); #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
